// File: rtl/mult_div_unit_pkg.sv
// Shared state encoding, iteration counts and constants for mult_div_unit.
// Iteration count for multiply depends on MULTDIV_BOOTH_RADIX4_EN.
package mult_div_unit_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MULT,
    S_DIV,
    S_DONE
  } state_t;

  localparam logic [31:0] MIN_INT = 32'h8000_0000;

  function automatic int multIters(input int width);
`ifdef MULTDIV_BOOTH_RADIX4_EN
    return width / 2;
`else
    return width;
`endif
  endfunction

  function automatic int divIters(input int width);
    return width;
  endfunction

endpackage

// File: rtl/mult_div_unit_if.sv
// Operand/result bus between the execute stage and mult_div_unit.
interface mult_div_unit_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_MULT;
  logic             ctrl_DIV;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;

  modport master (
    output data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    input  data_result, data_exception, data_resultRDY, busy
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_MULT, ctrl_DIV,
    output data_result, data_exception, data_resultRDY, busy
  );
endinterface

// File: rtl/mult_div_unit_div_step.sv
// One combinational restoring-division step on unsigned magnitudes.
module mult_div_unit_div_step #(parameter int WIDTH = 32) (
  input  logic [2*WIDTH-1:0] remQuoIn,
  input  logic [WIDTH-1:0]   divisor,
  output logic [2*WIDTH-1:0] remQuoOut
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] trial;

  // Shift the next dividend bit into the remainder and try subtracting.
  assign shifted   = remQuoIn[2*WIDTH-1:WIDTH-1];
  assign trial     = shifted - {1'b0, divisor};
  assign remQuoOut = trial[WIDTH] ? {shifted[WIDTH-1:0], remQuoIn[WIDTH-2:0], 1'b0}
                                  : {trial[WIDTH-1:0],   remQuoIn[WIDTH-2:0], 1'b1};
endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle signed Booth multiplier / restoring divider.
// Define MULTDIV_BOOTH_RADIX4_EN for a radix-4 Booth multiply (half the iterations).
module mult_div_unit
  import mult_div_unit_pkg::*;
#(parameter int WIDTH = 32) (
  input  logic            clock,
  input  logic            reset,
  mult_div_unit_if.slave  bus
);
  localparam int MULT_ITERS = multIters(WIDTH);
  localparam int DIV_ITERS  = divIters(WIDTH);
  localparam int CNT_W      = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state;
  logic [CNT_W-1:0]   iterCnt;
  logic [2*WIDTH:0]   acc;
  logic [2*WIDTH:0]   accNext;
  logic [WIDTH-1:0]   multiplicand;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] remQuo;
  logic [2*WIDTH-1:0] remQuoNext;
  logic [WIDTH-1:0]   divisorMag;
  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;
  logic [WIDTH-1:0]   quoNext;
  logic               negQuo;
  logic               divOverflow;
  logic [WIDTH-1:0]   resultReg;
  logic               excReg;
  logic               rdyReg;
  logic               busyReg;

  // acc = {high half, multiplier/low half, Booth guard bit}
`ifdef MULTDIV_BOOTH_RADIX4_EN
  logic [WIDTH+1:0] boothSum;
  logic [WIDTH+1:0] mcandExt;

  always_comb begin
    mcandExt = {{2{multiplicand[WIDTH-1]}}, multiplicand};
    boothSum = {{2{acc[2*WIDTH]}}, acc[2*WIDTH:WIDTH+1]};
    case (acc[2:0])
      3'b001, 3'b010: boothSum = boothSum + mcandExt;
      3'b011:         boothSum = boothSum + (mcandExt << 1);
      3'b100:         boothSum = boothSum - (mcandExt << 1);
      3'b101, 3'b110: boothSum = boothSum - mcandExt;
      default:        boothSum = boothSum;
    endcase
    accNext = {boothSum, acc[WIDTH:2]};
  end
`else
  logic [WIDTH:0] boothSum;
  logic [WIDTH:0] mcandExt;

  always_comb begin
    mcandExt = {multiplicand[WIDTH-1], multiplicand};
    boothSum = {acc[2*WIDTH], acc[2*WIDTH:WIDTH+1]};
    case (acc[1:0])
      2'b01:   boothSum = boothSum + mcandExt;
      2'b10:   boothSum = boothSum - mcandExt;
      default: boothSum = boothSum;
    endcase
    accNext = {boothSum, acc[WIDTH:1]};
  end
`endif

  assign product = accNext[2*WIDTH:1];
  assign magA    = bus.data_operandA[WIDTH-1] ? (~bus.data_operandA + 1'b1) : bus.data_operandA;
  assign magB    = bus.data_operandB[WIDTH-1] ? (~bus.data_operandB + 1'b1) : bus.data_operandB;
  assign quoNext = remQuoNext[WIDTH-1:0];

  mult_div_unit_div_step #(.WIDTH(WIDTH)) divStep (
    .remQuoIn  (remQuo),
    .divisor   (divisorMag),
    .remQuoOut (remQuoNext)
  );

  // A start pulse always wins over the current operation; multiply beats divide.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      iterCnt      <= '0;
      acc          <= '0;
      multiplicand <= '0;
      remQuo       <= '0;
      divisorMag   <= '0;
      negQuo       <= 1'b0;
      divOverflow  <= 1'b0;
      resultReg    <= '0;
      excReg       <= 1'b0;
      rdyReg       <= 1'b0;
      busyReg      <= 1'b0;
    end else begin
      rdyReg <= 1'b0;
      if (bus.ctrl_MULT) begin
        state        <= S_MULT;
        busyReg      <= 1'b1;
        iterCnt      <= '0;
        multiplicand <= bus.data_operandA;
        acc          <= {{WIDTH{1'b0}}, bus.data_operandB, 1'b0};
      end else if (bus.ctrl_DIV) begin
        busyReg     <= 1'b1;
        iterCnt     <= '0;
        divisorMag  <= magB;
        remQuo      <= {{WIDTH{1'b0}}, magA};
        negQuo      <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
        divOverflow <= (bus.data_operandA == MIN_VAL) && (&bus.data_operandB);
        if (bus.data_operandB == '0) begin
          state     <= S_DONE;
          rdyReg    <= 1'b1;
          resultReg <= '0;
          excReg    <= 1'b1;
        end else begin
          state <= S_DIV;
        end
      end else begin
        case (state)
          S_MULT: begin
            acc     <= accNext;
            iterCnt <= iterCnt + CNT_W'(1);
            if (iterCnt == CNT_W'(MULT_ITERS - 1)) begin
              state     <= S_DONE;
              rdyReg    <= 1'b1;
              resultReg <= product[WIDTH-1:0];
              excReg    <= ~((&product[2*WIDTH-1:WIDTH-1]) | ~(|product[2*WIDTH-1:WIDTH-1]));
            end
          end
          S_DIV: begin
            remQuo  <= remQuoNext;
            iterCnt <= iterCnt + CNT_W'(1);
            if (iterCnt == CNT_W'(DIV_ITERS - 1)) begin
              state     <= S_DONE;
              rdyReg    <= 1'b1;
              resultReg <= divOverflow ? MIN_VAL : (negQuo ? (~quoNext + 1'b1) : quoNext);
              excReg    <= divOverflow;
            end
          end
          S_DONE: begin
            state   <= S_IDLE;
            busyReg <= 1'b0;
          end
          default: begin
            state   <= S_IDLE;
            busyReg <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.data_result    = resultReg;
  assign bus.data_exception = excReg;
  assign bus.data_resultRDY = rdyReg;
  assign bus.busy           = busyReg;
endmodule
